// File: rtl/branch_control_unit.sv
// ---------------------------------------------------------------------------
// branch_control_unit
//
// Moore sequencer for fetch and conditional-branch execution in a simple
// bus-based datapath. Walks IDLE -> T0..T6, decodes the opcode in T3 and
// latches the branch condition from the bus into con_ff. A halt opcode parks
// the machine in HALT until reset.
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   run        level, permits starting a new instruction
//   mem_ready  memory read data valid (ends the T1 wait)
//   ir         current instruction register contents
//   bus_in     datapath bus, evaluated for the branch condition in T3
//   PCout .. ALUen  datapath control strobes
//   ra_sel     register select, ir[26:23] while Raout is high, else 0
//   con_ff     latched branch condition
//   halted     high while parked in HALT
//   state_out  present state code
// ---------------------------------------------------------------------------
module branch_control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  input  logic [31:0] bus_in,
  output logic        PCout,
  output logic        MARins,
  output logic        incPC,
  output logic        ZLOins,
  output logic        ZLOout,
  output logic        PCins,
  output logic        MDRRead,
  output logic        MDRins,
  output logic        MDRout,
  output logic        IRins,
  output logic        Yins,
  output logic        Raout,
  output logic        Cout,
  output logic        ALUen,
  output logic [3:0]  ra_sel,
  output logic        con_ff,
  output logic        halted,
  output logic [3:0]  state_out
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_BRZR = 5'b11100;
  localparam logic [4:0] OP_BRPL = 5'b11101;
  localparam logic [4:0] OP_BRNZ = 5'b11110;
  localparam logic [4:0] OP_BRMI = 5'b11111;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state;
  logic       t1_wait;
  logic [4:0] opcode;
  logic       is_branch;
  logic       is_halt;
  logic       bus_zero;
  logic       cond_met;
  logic       unused_ir_bits;

  assign opcode         = ir[31:27];
  assign unused_ir_bits = ^ir[22:0];

  // Opcode classification and branch condition evaluation.
  always_comb begin
    is_branch = 1'b0;
    is_halt   = 1'b0;
    cond_met  = 1'b0;
    bus_zero  = (bus_in == 32'd0);
    case (opcode)
      OP_BRZR: begin is_branch = 1'b1; cond_met = bus_zero; end
      OP_BRNZ: begin is_branch = 1'b1; cond_met = !bus_zero; end
      OP_BRPL: begin is_branch = 1'b1; cond_met = !bus_in[31] && !bus_zero; end
      OP_BRMI: begin is_branch = 1'b1; cond_met = bus_in[31]; end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  // State register plus the condition flag, the halt flag and the T1 wait
  // marker. t1_wait is set only when T1 is re-entered because memory was not
  // ready, so the PC update strobes fire in the first T1 cycle only.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      con_ff  <= 1'b0;
      halted  <= 1'b0;
      t1_wait <= 1'b0;
    end else begin
      t1_wait <= 1'b0;
      case (state)
        IDLE: if (run) state <= T0;
        T0:   state <= T1;
        T1: begin
          if (mem_ready) begin
            state <= T2;
          end else begin
            t1_wait <= 1'b1;
          end
        end
        T2:   state <= T3;
        T3: begin
          if (is_branch) begin
            state  <= T4;
            con_ff <= cond_met;
          end else if (is_halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state <= run ? T0 : IDLE;
          end
        end
        T4:   state <= T5;
        T5:   state <= T6;
        T6:   state <= run ? T0 : IDLE;
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobe decode from the state register. Raout in T3 also needs the opcode,
  // and T6 gates the PC load with the latched condition. Only one bus driver
  // (PCout, ZLOout, MDRout, Raout, Cout) is ever high in a given state.
  always_comb begin
    PCout   = 1'b0;
    MARins  = 1'b0;
    incPC   = 1'b0;
    ZLOins  = 1'b0;
    ZLOout  = 1'b0;
    PCins   = 1'b0;
    MDRRead = 1'b0;
    MDRins  = 1'b0;
    MDRout  = 1'b0;
    IRins   = 1'b0;
    Yins    = 1'b0;
    Raout   = 1'b0;
    Cout    = 1'b0;
    ALUen   = 1'b0;
    case (state)
      T0: begin
        PCout  = 1'b1;
        MARins = 1'b1;
        incPC  = 1'b1;
        ZLOins = 1'b1;
      end
      T1: begin
        ZLOout  = !t1_wait;
        PCins   = !t1_wait;
        MDRRead = 1'b1;
        MDRins  = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRins  = 1'b1;
      end
      T3: Raout = is_branch;
      T4: begin
        PCout = 1'b1;
        Yins  = 1'b1;
      end
      T5: begin
        Cout   = 1'b1;
        ALUen  = 1'b1;
        ZLOins = 1'b1;
      end
      T6: begin
        ZLOout = con_ff;
        PCins  = con_ff;
      end
      default: ;
    endcase
  end

  assign ra_sel    = Raout ? ir[26:23] : 4'd0;
  assign state_out = state;

endmodule

// File: tb/tb_branch_control_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_control_unit
//
// Directed testbench for branch_control_unit. Each scenario task drives its
// own stimulus and compares outputs on the falling clock edge against
// hand-computed state codes and strobe patterns.
// ---------------------------------------------------------------------------
module tb_branch_control_unit;

  logic        clk;
  logic        clr;
  logic        run;
  logic        mem_ready;
  logic [31:0] ir;
  logic [31:0] bus_in;
  logic        PCout, MARins, incPC, ZLOins, ZLOout, PCins, MDRRead;
  logic        MDRins, MDRout, IRins, Yins, Raout, Cout, ALUen;
  logic [3:0]  ra_sel;
  logic        con_ff;
  logic        halted;
  logic [3:0]  state_out;
  logic [13:0] strobes;

  int vec_count = 0;
  int err_count = 0;

  // Strobe order: PCout MARins incPC ZLOins ZLOout PCins MDRRead MDRins
  //               MDRout IRins Yins Raout Cout ALUen
  localparam logic [13:0] SB_NONE = 14'b00000000000000;
  localparam logic [13:0] SB_T0   = 14'b11110000000000;
  localparam logic [13:0] SB_T1F  = 14'b00001111000000;
  localparam logic [13:0] SB_T1W  = 14'b00000011000000;
  localparam logic [13:0] SB_T2   = 14'b00000000110000;
  localparam logic [13:0] SB_T3B  = 14'b00000000000100;
  localparam logic [13:0] SB_T4   = 14'b10000000001000;
  localparam logic [13:0] SB_T5   = 14'b00010000000011;
  localparam logic [13:0] SB_T6T  = 14'b00001100000000;

  localparam logic [3:0]  SEQ_ST [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
  localparam logic [13:0] SEQ_SB [7] = '{SB_T0, SB_T1F, SB_T2, SB_T3B, SB_T4, SB_T5, SB_T6T};

  assign strobes = {PCout, MARins, incPC, ZLOins, ZLOout, PCins, MDRRead,
                    MDRins, MDRout, IRins, Yins, Raout, Cout, ALUen};

  branch_control_unit dut (
    .clk       (clk),
    .clr       (clr),
    .run       (run),
    .mem_ready (mem_ready),
    .ir        (ir),
    .bus_in    (bus_in),
    .PCout     (PCout),
    .MARins    (MARins),
    .incPC     (incPC),
    .ZLOins    (ZLOins),
    .ZLOout    (ZLOout),
    .PCins     (PCins),
    .MDRRead   (MDRRead),
    .MDRins    (MDRins),
    .MDRout    (MDRout),
    .IRins     (IRins),
    .Yins      (Yins),
    .Raout     (Raout),
    .Cout      (Cout),
    .ALUen     (ALUen),
    .ra_sel    (ra_sel),
    .con_ff    (con_ff),
    .halted    (halted),
    .state_out (state_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence never completes.
  initial begin
    #200000;
    $display("[TB] FAIL timeout got running want finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Puts the DUT into IDLE with run low; returns just after reset release.
  task automatic apply_reset();
    @(negedge clk);
    run       = 1'b0;
    mem_ready = 1'b1;
    clr       = 1'b0;
    #2;
    clr = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = 32'hE800_01FF; bus_in = 32'h12;
    @(negedge clk);
    vec_count++; if (state_out !== 4'd0) begin err_count++; $display("[TB] FAIL reset_state got %0d want 0", state_out); end
    vec_count++; if (strobes !== SB_NONE) begin err_count++; $display("[TB] FAIL reset_strobes got %b want %b", strobes, SB_NONE); end
    vec_count++; if ({con_ff, halted, ra_sel} !== 6'd0) begin err_count++; $display("[TB] FAIL reset_flags got %b want 000000", {con_ff, halted, ra_sel}); end
    clr = 1'b1;
    #1;
    vec_count++; if (state_out !== 4'd0) begin err_count++; $display("[TB] FAIL release_no_early got %0d want 0", state_out); end
    @(negedge clk);
    vec_count++; if (state_out !== 4'd1) begin err_count++; $display("[TB] FAIL release_first_edge got %0d want 1", state_out); end
  endtask

  task automatic test_brpl_taken();
    apply_reset();
    ir = 32'hE800_01FF; bus_in = 32'h12; run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      vec_count++; if (state_out !== SEQ_ST[i]) begin err_count++; $display("[TB] FAIL brpl_state[%0d] got %0d want %0d", i, state_out, SEQ_ST[i]); end
      vec_count++; if (strobes !== SEQ_SB[i]) begin err_count++; $display("[TB] FAIL brpl_strobes[%0d] got %b want %b", i, strobes, SEQ_SB[i]); end
    end
    vec_count++; if (con_ff !== 1'b1) begin err_count++; $display("[TB] FAIL brpl_con_ff got %b want 1", con_ff); end
    vec_count++; if (PCins !== 1'b1) begin err_count++; $display("[TB] FAIL brpl_pcins_t6 got %b want 1", PCins); end
    @(negedge clk);
    vec_count++; if (state_out !== 4'd1) begin err_count++; $display("[TB] FAIL brpl_next got %0d want 1", state_out); end
  endtask

  // Continues straight from the taken brpl, so con_ff must drop from 1 to 0.
  task automatic test_brzr_not_taken();
    logic [13:0] exp_sb;
    ir = 32'hE000_01FF; bus_in = 32'h22;
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      exp_sb = (i == 6) ? SB_NONE : SEQ_SB[i];
      vec_count++; if (state_out !== SEQ_ST[i]) begin err_count++; $display("[TB] FAIL brzr_state[%0d] got %0d want %0d", i, state_out, SEQ_ST[i]); end
      vec_count++; if (strobes !== exp_sb) begin err_count++; $display("[TB] FAIL brzr_strobes[%0d] got %b want %b", i, strobes, exp_sb); end
      if (i == 3) begin
        vec_count++; if (con_ff !== 1'b1) begin err_count++; $display("[TB] FAIL brzr_con_hold got %b want 1", con_ff); end
      end
      if (i == 4) begin
        vec_count++; if (con_ff !== 1'b0) begin err_count++; $display("[TB] FAIL brzr_con_ff got %b want 0", con_ff); end
      end
    end
    @(negedge clk);
    vec_count++; if (state_out !== 4'd1) begin err_count++; $display("[TB] FAIL brzr_next got %0d want 1", state_out); end
  endtask

  task automatic test_mem_wait();
    logic [13:0] exp_sb;
    apply_reset();
    ir = 32'hE800_01FF; bus_in = 32'h12; run = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    vec_count++; if (state_out !== 4'd1) begin err_count++; $display("[TB] FAIL wait_t0 got %0d want 1", state_out); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      exp_sb = (c == 0) ? SB_T1F : SB_T1W;
      vec_count++; if (state_out !== 4'd2) begin err_count++; $display("[TB] FAIL wait_t1[%0d] got %0d want 2", c, state_out); end
      vec_count++; if (strobes !== exp_sb) begin err_count++; $display("[TB] FAIL wait_strobes[%0d] got %b want %b", c, strobes, exp_sb); end
    end
    mem_ready = 1'b1;
    @(negedge clk);
    vec_count++; if (state_out !== 4'd3) begin err_count++; $display("[TB] FAIL wait_t2 got %0d want 3", state_out); end
    vec_count++; if (strobes !== SB_T2) begin err_count++; $display("[TB] FAIL wait_t2_strobes got %b want %b", strobes, SB_T2); end
  endtask

  task automatic test_brnz_brmi();
    apply_reset();
    ir = 32'hF000_0000; bus_in = 32'h0; run = 1'b1;
    repeat (5) @(negedge clk);
    vec_count++; if ({state_out, con_ff} !== {4'd5, 1'b0}) begin err_count++; $display("[TB] FAIL brnz_zero got st=%0d con=%b want st=5 con=0", state_out, con_ff); end
    repeat (2) @(negedge clk);
    vec_count++; if (strobes !== SB_NONE) begin err_count++; $display("[TB] FAIL brnz_t6 got %b want %b", strobes, SB_NONE); end
    @(negedge clk);
    ir = 32'hF980_0000; bus_in = 32'h8000_0000;
    repeat (3) @(negedge clk);
    vec_count++; if ({Raout, ra_sel} !== {1'b1, 4'd3}) begin err_count++; $display("[TB] FAIL brmi_rasel got %b/%0d want 1/3", Raout, ra_sel); end
    @(negedge clk);
    vec_count++; if (con_ff !== 1'b1) begin err_count++; $display("[TB] FAIL brmi_neg got %b want 1", con_ff); end
    repeat (2) @(negedge clk);
    vec_count++; if (strobes !== SB_T6T) begin err_count++; $display("[TB] FAIL brmi_t6 got %b want %b", strobes, SB_T6T); end
    @(negedge clk);
    ir = 32'hE800_0000; bus_in = 32'h0;
    repeat (4) @(negedge clk);
    vec_count++; if ({state_out, con_ff} !== {4'd5, 1'b0}) begin err_count++; $display("[TB] FAIL brpl_zero got st=%0d con=%b want st=5 con=0", state_out, con_ff); end
  endtask

  task automatic test_noop();
    apply_reset();
    ir = 32'h0000_0000; bus_in = 32'h0; run = 1'b1;
    repeat (4) @(negedge clk);
    vec_count++; if ({state_out, strobes} !== {4'd4, SB_NONE}) begin err_count++; $display("[TB] FAIL noop_t3 got st=%0d sb=%b want st=4 sb=0", state_out, strobes); end
    @(negedge clk);
    vec_count++; if (state_out !== 4'd1) begin err_count++; $display("[TB] FAIL noop_next got %0d want 1", state_out); end
    run = 1'b0;
    repeat (4) @(negedge clk);
    vec_count++; if (state_out !== 4'd0) begin err_count++; $display("[TB] FAIL noop_idle got %0d want 0", state_out); end
  endtask

  task automatic test_halt();
    apply_reset();
    ir = 32'hD800_0000; bus_in = 32'h0; run = 1'b1;
    repeat (4) @(negedge clk);
    vec_count++; if ({state_out, strobes, halted} !== {4'd4, SB_NONE, 1'b0}) begin err_count++; $display("[TB] FAIL halt_t3 got st=%0d sb=%b h=%b want st=4 sb=0 h=0", state_out, strobes, halted); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vec_count++; if ({state_out, halted, strobes} !== {4'd8, 1'b1, SB_NONE}) begin err_count++; $display("[TB] FAIL halt_hold[%0d] got st=%0d h=%b sb=%b want st=8 h=1 sb=0", c, state_out, halted, strobes); end
    end
    run = 1'b0;
    #1 clr = 1'b0;
    #1;
    vec_count++; if ({state_out, halted} !== {4'd0, 1'b0}) begin err_count++; $display("[TB] FAIL halt_clr got st=%0d h=%b want st=0 h=0", state_out, halted); end
    #1 clr = 1'b1;
    @(negedge clk);
    vec_count++; if (state_out !== 4'd0) begin err_count++; $display("[TB] FAIL halt_after got %0d want 0", state_out); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    ir = 32'hE800_01FF; bus_in = 32'h12; run = 1'b1;
    repeat (6) @(negedge clk);
    vec_count++; if ({state_out, strobes} !== {4'd6, SB_T5}) begin err_count++; $display("[TB] FAIL t5_before got st=%0d sb=%b want st=6 sb=%b", state_out, strobes, SB_T5); end
    #1 clr = 1'b0;
    #1;
    vec_count++; if ({state_out, strobes, con_ff, ra_sel} !== {4'd0, SB_NONE, 1'b0, 4'd0}) begin err_count++; $display("[TB] FAIL t5_async got st=%0d sb=%b con=%b ra=%0d want all 0", state_out, strobes, con_ff, ra_sel); end
    run = 1'b0;
    #1 clr = 1'b1;
    @(negedge clk);
    vec_count++; if (state_out !== 4'd0) begin err_count++; $display("[TB] FAIL t5_idle got %0d want 0", state_out); end
    run = 1'b1; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    vec_count++; if ({state_out, strobes} !== {4'd2, SB_T1W}) begin err_count++; $display("[TB] FAIL t1w_before got st=%0d sb=%b want st=2 sb=%b", state_out, strobes, SB_T1W); end
    #1 clr = 1'b0;
    #1;
    vec_count++; if (state_out !== 4'd0) begin err_count++; $display("[TB] FAIL t1w_async got %0d want 0", state_out); end
    run = 1'b0; mem_ready = 1'b1;
    #1 clr = 1'b1;
    @(negedge clk);
    vec_count++; if (state_out !== 4'd0) begin err_count++; $display("[TB] FAIL t1w_idle got %0d want 0", state_out); end
    run = 1'b1;
    repeat (2) @(negedge clk);
    vec_count++; if ({state_out, strobes} !== {4'd2, SB_T1F}) begin err_count++; $display("[TB] FAIL t1w_restart got st=%0d sb=%b want st=2 sb=%b", state_out, strobes, SB_T1F); end
  endtask

  task automatic test_run_drop();
    logic [3:0] exp_st [4] = '{4'd6, 4'd7, 4'd0, 4'd0};
    apply_reset();
    ir = 32'hE800_01FF; bus_in = 32'h12; run = 1'b1;
    repeat (5) @(negedge clk);
    vec_count++; if (state_out !== 4'd5) begin err_count++; $display("[TB] FAIL drop_t4 got %0d want 5", state_out); end
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vec_count++; if (state_out !== exp_st[i]) begin err_count++; $display("[TB] FAIL drop_state[%0d] got %0d want %0d", i, state_out, exp_st[i]); end
      if (i == 1) begin
        vec_count++; if (strobes !== SB_T6T) begin err_count++; $display("[TB] FAIL drop_t6 got %b want %b", strobes, SB_T6T); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_brpl_taken();
    test_brzr_not_taken();
    test_mem_wait();
    test_brnz_brmi();
    test_noop();
    test_halt();
    test_async_reset();
    test_run_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
